bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 256: the number of idle owner cycles after which the bus is revoked; legal range 2..65535.
REQ-002 Parameter CNT_WIDTH, default 16: the idle-counter width; it SHALL satisfy 2^CNT_WIDTH > TIMEOUT.
REQ-003 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 m1_breq, m2_breq  input  1 each  bus request; the master holds it high for the whole transaction.
REQ-006 m1_mvalid, m2_mvalid  input  1 each  master serial-data-valid, used as an activity indicator.
REQ-007 m1_svalid, m2_svalid  input  1 each  slave-response-valid routed to each master, used as an activity indicator.
REQ-008 s_ready  input  1  AND of all slave ready signals.
REQ-009 m1_bgrant, m2_bgrant  output  1 each  registered bus grant.
REQ-010 msel  output  1  registered master-mux select for the bus datapath: 0 selects master 1, 1 selects master 2.
REQ-011 bus_busy  output  1  high while either grant is high.
REQ-012 timeout  output  1  one-cycle pulse when a grant is revoked.

Function
REQ-013 FSM states: IDLE, GRANT1, GRANT2, TURN; all outputs SHALL be registered.
REQ-014 IDLE, s_ready=1, at least one eligible request: go to GRANT1 or GRANT2; the grant is high on the cycle after the request is sampled (1-cycle latency).
REQ-015 IDLE, s_ready=0: stay in IDLE; no grant regardless of requests.
REQ-016 Simultaneous eligible requests: grant the master not served last (round-robin via a last_owner flop); last_owner resets to master 2, so master 1 wins the first tie.
REQ-017 m1_bgrant and m2_bgrant SHALL never both be high in any cycle.
REQ-018 GRANTx with owner breq=1: hold the grant; msel is stable for the whole grant.
REQ-019 GRANTx with owner breq=0: go to TURN; the grant drops the next cycle and last_owner updates to x.
REQ-020 TURN lasts exactly one cycle, with both grants low (bus turnaround), then go to IDLE; earliest re-grant is 2 cycles after the grant drops.
REQ-021 msel updates only on entry to GRANTx and holds its value through TURN and IDLE.
REQ-022 Idle counter: clear on entry to GRANTx and on any cycle with owner mvalid=1 or owner svalid=1; otherwise increment, saturating at its maximum.
REQ-023 When the idle counter reaches TIMEOUT-1 in GRANTx with owner breq=1: go to TURN, pulse timeout in the same cycle the grant drops, and set block_x.
REQ-024 block_x set makes master x ineligible; block_x clears on the first cycle its breq is sampled low.
REQ-025 Non-owner mvalid/svalid SHALL be ignored by the counter.
REQ-026 A request that drops while waiting in IDLE is withdrawn without a grant; no state is retained for it.
REQ-027 s_ready falling during GRANTx SHALL NOT revoke the grant; s_ready gates new grants only.

Reset
REQ-028 rst=1 asynchronously forces: state=IDLE, m1_bgrant=0, m2_bgrant=0, msel=0, bus_busy=0, timeout=0, counter=0, last_owner=master 2, block_1=0, block_2=0.
REQ-029 Reset mid-grant drops the grant immediately; the first grant after rst falls is issued no earlier than 1 cycle after a request is sampled.

Structure
REQ-030 A shared bus package SHALL hold the FSM state encoding, the master-index constants (M1=0, M2=1) and the default TIMEOUT.
REQ-031 A single sub-module, arb_idle_timer (the saturating counter with clear and terminal-count output), SHALL be instantiated once; all other logic is flat.

Verification
REQ-032 Reset, then m1_breq=1 at cycle 0 with s_ready=1 -> m1_bgrant=1 and msel=0 at cycle 1; m2_bgrant=0 throughout.
REQ-033 m1_breq and m2_breq high together from IDLE after reset -> master 1 granted; m1_breq drops -> 1 TURN cycle with no grant, then m2_bgrant=1 with msel=1.
REQ-034 s_ready=0 with m2_breq=1 for 10 cycles -> no grant; s_ready rises -> m2_bgrant=1 on the next cycle.
REQ-035 TIMEOUT=8, m1 granted, m1_breq held high, no mvalid/svalid -> grant drops and timeout pulses once, 8 cycles after the grant; m1 stays ungranted until m1_breq toggles low then high.
REQ-036 TIMEOUT=8, owner mvalid pulsed every 5 cycles for 40 cycles -> no timeout pulse; m2 mvalid activity alone with m1 owning -> timeout.
REQ-037 rst asserted mid-GRANT2 -> m2_bgrant, bus_busy and msel=0 in the same cycle; after release, a tie grants master 1.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, master indices and
// default timing parameters.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT1 = 2'd1,
    ST_GRANT2 = 2'd2,
    ST_TURN   = 2'd3
  } arb_state_e;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  localparam int DEF_TIMEOUT   = 256;
  localparam int DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/arb_idle_timer.sv
// Saturating idle counter with synchronous clear; o_tc flags the last
// idle count before the bus owner is revoked.
module arb_idle_timer #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [CNT_WIDTH-1:0] TC_VAL = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with turnaround cycle and
// idle-owner revocation.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_breq,
  input  logic m2_breq,
  input  logic m1_mvalid,
  input  logic m2_mvalid,
  input  logic m1_svalid,
  input  logic m2_svalid,
  input  logic s_ready,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  output logic bus_busy,
  output logic timeout
);

  arb_state_e r_state;
  arb_state_e w_next;

  logic r_last;
  logic r_blk1;
  logic r_blk2;
  logic r_g1;
  logic r_g2;
  logic r_msel;
  logic r_busy;
  logic r_to;

  logic w_in_grant;
  logic w_owner;
  logic w_own_breq;
  logic w_act;
  logic w_tc;
  logic w_revoke;
  logic w_elig1;
  logic w_elig2;
  logic w_pick;
  logic w_entry;
  logic w_clr;

  logic w_g1_nxt;
  logic w_g2_nxt;
  logic w_msel_nxt;
  logic w_busy_nxt;
  logic w_to_nxt;
  logic w_last_nxt;
  logic w_blk1_nxt;
  logic w_blk2_nxt;

  assign w_in_grant = (r_state == ST_GRANT1) ||
                      (r_state == ST_GRANT2);
  assign w_owner    = (r_state == ST_GRANT2) ? M2 : M1;

  assign w_own_breq = (w_owner == M2) ? m2_breq : m1_breq;

  // Only the current owner's traffic counts as activity
  assign w_act = w_in_grant &&
                 ((w_owner == M2) ? (m2_mvalid || m2_svalid)
                                  : (m1_mvalid || m1_svalid));

  assign w_revoke = w_in_grant && w_own_breq && w_tc && !w_act;

  assign w_elig1 = m1_breq && !r_blk1;
  assign w_elig2 = m2_breq && !r_blk2;

  always_comb begin
    w_pick = M1;
    if (w_elig1 && w_elig2) begin
      w_pick = (r_last == M1) ? M2 : M1;
    end else if (w_elig2) begin
      w_pick = M2;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (s_ready && (w_elig1 || w_elig2)) begin
          w_next = (w_pick == M2) ? ST_GRANT2 : ST_GRANT1;
        end
      end
      ST_GRANT1, ST_GRANT2: begin
        if (!w_own_breq || w_revoke) begin
          w_next = ST_TURN;
        end
      end
      ST_TURN: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_entry = (r_state == ST_IDLE) && (w_next != ST_IDLE);
  assign w_clr   = w_entry || w_act;

  arb_idle_timer #(
    .CNT_WIDTH (CNT_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_g1_nxt   = (w_next == ST_GRANT1);
    w_g2_nxt   = (w_next == ST_GRANT2);
    w_busy_nxt = w_g1_nxt || w_g2_nxt;
    w_to_nxt   = w_revoke;
    w_msel_nxt = r_msel;
    w_last_nxt = r_last;
    w_blk1_nxt = r_blk1;
    w_blk2_nxt = r_blk2;
    if (w_entry) begin
      w_msel_nxt = w_pick;
    end
    if (w_in_grant && (w_next == ST_TURN)) begin
      w_last_nxt = w_owner;
    end
    // A block is lifted once the master lets its request go
    if (w_revoke && (w_owner == M1)) begin
      w_blk1_nxt = 1'b1;
    end else if (!m1_breq) begin
      w_blk1_nxt = 1'b0;
    end
    if (w_revoke && (w_owner == M2)) begin
      w_blk2_nxt = 1'b1;
    end else if (!m2_breq) begin
      w_blk2_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g1   <= 1'b0;
      r_g2   <= 1'b0;
      r_msel <= 1'b0;
      r_busy <= 1'b0;
      r_to   <= 1'b0;
      r_last <= M2;
      r_blk1 <= 1'b0;
      r_blk2 <= 1'b0;
    end else begin
      r_g1   <= w_g1_nxt;
      r_g2   <= w_g2_nxt;
      r_msel <= w_msel_nxt;
      r_busy <= w_busy_nxt;
      r_to   <= w_to_nxt;
      r_last <= w_last_nxt;
      r_blk1 <= w_blk1_nxt;
      r_blk2 <= w_blk2_nxt;
    end
  end

  assign m1_bgrant = r_g1;
  assign m2_bgrant = r_g2;
  assign msel      = r_msel;
  assign bus_busy  = r_busy;
  assign timeout   = r_to;

endmodule
